// File: rtl/dec_pkg.sv
// Shared definitions for the 491.52 -> 245.76 Msps decimator: default widths,
// the rounding/saturation constants and helpers, and signed sample/accumulator types.
package dec_pkg;

  localparam int DEC_W1 = 16;
  localparam int DEC_W2 = 32;
  localparam int DEC_W3 = 36;
  localparam int SHIFT  = 15;

  typedef logic signed [DEC_W1-1:0] sample_t;
  typedef logic signed [DEC_W3-1:0] acc_t;

  localparam acc_t ROUND_CONST = 36'sd16384;
  localparam acc_t SAT_MAX     = 36'sd32767;
  localparam acc_t SAT_MIN     = -36'sd32768;

  // Round half up and drop the Q15 fraction bits of the filter sum.
  function automatic acc_t round_shift(input acc_t a);
    acc_t t;
    t = a + ROUND_CONST;
    return t >>> SHIFT;
  endfunction

  // True when a rounded value lies outside the output sample range.
  function automatic logic is_clipped(input acc_t y);
    return (y > SAT_MAX) || (y < SAT_MIN);
  endfunction

  // Clamp a rounded value to the signed 16-bit output range.
  function automatic sample_t saturate(input acc_t y);
    sample_t r;
    if (y > SAT_MAX) begin
      r = 16'sh7FFF;
    end else if (y < SAT_MIN) begin
      r = 16'sh8000;
    end else begin
      r = y[DEC_W1-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/dec_adder_tree.sv
// Pipelined signed sum of L products. The log2(L) tree levels are spread over
// Mpipe register stages, earliest stages taking the extra levels; a vld/ca
// sideband travels alongside with the same depth.
module dec_adder_tree
  import dec_pkg::*;
#(
  parameter int L     = 16,
  parameter int W2    = DEC_W2,
  parameter int W3    = DEC_W3,
  parameter int Mpipe = 3
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vld,
  input  logic              i_ca,
  input  logic [L*W2-1:0]   i_prod,
  output logic              o_vld,
  output logic              o_ca,
  output logic [W3-1:0]     o_sum
);

  localparam int LOGL  = $clog2(L);
  localparam int BASE  = LOGL / Mpipe;
  localparam int EXTRA = LOGL % Mpipe;

  function automatic int levels(input int s);
    return BASE + ((s < EXTRA) ? 1 : 0);
  endfunction

  function automatic int group(input int s);
    return 1 << levels(s);
  endfunction

  // Number of partial sums still alive after stage s.
  function automatic int width_out(input int s);
    int n;
    n = L;
    for (int k = 0; k <= s; k++) begin
      n = n >> levels(k);
    end
    return n;
  endfunction

  logic signed [W3-1:0] w_src [Mpipe][L];
  logic signed [W3-1:0] w_nxt [Mpipe][L];
  logic signed [W3-1:0] r_stg [Mpipe][L];
  logic [Mpipe-1:0]     r_vld;
  logic [Mpipe-1:0]     r_ca;

  // Stage inputs: sign-extended products for the first stage, previous stage otherwise.
  always_comb begin
    for (int s = 0; s < Mpipe; s++) begin
      for (int j = 0; j < L; j++) begin
        w_src[s][j] = '0;
      end
    end
    for (int j = 0; j < L; j++) begin
      w_src[0][j] = W3'(signed'(i_prod[j*W2 +: W2]));
    end
    for (int s = 1; s < Mpipe; s++) begin
      for (int j = 0; j < L; j++) begin
        w_src[s][j] = r_stg[s-1][j];
      end
    end
  end

  // Each stage sums consecutive groups of 2^levels inputs.
  always_comb begin
    for (int s = 0; s < Mpipe; s++) begin
      for (int j = 0; j < L; j++) begin
        logic signed [W3-1:0] v_acc;
        v_acc = '0;
        if (j < width_out(s)) begin
          for (int t = 0; t < L; t++) begin
            if (t < group(s)) begin
              v_acc = v_acc + w_src[s][j*group(s)+t];
            end else begin
              v_acc = v_acc;
            end
          end
        end else begin
          v_acc = '0;
        end
        w_nxt[s][j] = v_acc;
      end
    end
  end

  // Stage registers and the matching vld/ca shift pipeline.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int s = 0; s < Mpipe; s++) begin
        for (int j = 0; j < L; j++) begin
          r_stg[s][j] <= '0;
        end
      end
      r_vld <= '0;
      r_ca  <= '0;
    end else begin
      r_stg    <= w_nxt;
      r_vld[0] <= i_vld;
      r_ca[0]  <= i_ca;
      for (int s = 1; s < Mpipe; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_ca[s]  <= r_ca[s-1];
      end
    end
  end

  assign o_vld = r_vld[Mpipe-1];
  assign o_ca  = r_ca[Mpipe-1];
  assign o_sum = r_stg[Mpipe-1][0];

endmodule

// File: rtl/down491m_to_245m.sv
// Decimate-by-2 FIR stage (491.52 -> 245.76 Msps) on the DDC receive path.
// Holds the delay line, coefficient registers with burst-load pointer, phase
// tracking, multiplier stage and the round/saturate output register.
// Optional macro DEC_SAT_FLAG_EN adds o_sat_flag, pulsing with a clipped output.
module down491m_to_245m
  import dec_pkg::*;
#(
  parameter int W1    = DEC_W1,
  parameter int W2    = DEC_W2,
  parameter int W3    = DEC_W3,
  parameter int L     = 16,
  parameter int Mpipe = 3
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_data_vld,
  input  logic          i_data_ca,
  input  logic [W1-1:0] i_data,
  input  logic          i_load_parameter,
  input  logic [W1-1:0] i_parameter_data,
  output logic          o_data_vld,
  output logic          o_data_ca,
  output logic [W1-1:0] o_data
`ifdef DEC_SAT_FLAG_EN
  ,
  output logic          o_sat_flag
`endif
);

  localparam int PW = $clog2(L);

  logic signed [W1-1:0] r_x [L];
  logic signed [W1-1:0] r_h [L];
  logic [PW-1:0]        r_ptr;
  logic                 r_phase;
  logic                 r_launch;
  logic                 r_launch_ca;
  logic [L*W2-1:0]      r_prod;
  logic                 r_p_vld;
  logic                 r_p_ca;
  logic                 w_cur_phase;
  logic                 w_t_vld;
  logic                 w_t_ca;
  logic [W3-1:0]        w_sum;
  acc_t                 w_y;

  // Phase of the sample on the input: a ca marker forces phase 0.
  always_comb begin
    w_cur_phase = 1'b0;
    if (i_data_ca) begin
      w_cur_phase = 1'b0;
    end else begin
      w_cur_phase = r_phase;
    end
  end

  // Delay line shift, phase toggle and launch flag for phase-0 samples.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < L; i++) begin
        r_x[i] <= '0;
      end
      r_phase     <= 1'b0;
      r_launch    <= 1'b0;
      r_launch_ca <= 1'b0;
    end else if (i_data_vld) begin
      r_x[0] <= i_data;
      for (int i = 1; i < L; i++) begin
        r_x[i] <= r_x[i-1];
      end
      r_phase     <= ~w_cur_phase;
      r_launch    <= ~w_cur_phase;
      r_launch_ca <= i_data_ca;
    end else begin
      r_launch    <= 1'b0;
      r_launch_ca <= 1'b0;
    end
  end

  // Coefficient burst load; the pointer restarts at h[0] whenever the strobe drops.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      for (int i = 0; i < L; i++) begin
        r_h[i] <= '0;
      end
      r_ptr <= '0;
    end else if (i_load_parameter) begin
      r_h[r_ptr] <= i_parameter_data;
      r_ptr      <= r_ptr + PW'(1'b1);
    end else begin
      r_ptr <= '0;
    end
  end

  // Registered tap products using the coefficients as currently held.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_prod  <= '0;
      r_p_vld <= 1'b0;
      r_p_ca  <= 1'b0;
    end else begin
      for (int i = 0; i < L; i++) begin
        r_prod[i*W2 +: W2] <= W2'(r_x[i]) * W2'(r_h[i]);
      end
      r_p_vld <= r_launch;
      r_p_ca  <= r_launch_ca;
    end
  end

  dec_adder_tree #(
    .L     (L),
    .W2    (W2),
    .W3    (W3),
    .Mpipe (Mpipe)
  ) u_tree (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_vld  (r_p_vld),
    .i_ca   (r_p_ca),
    .i_prod (r_prod),
    .o_vld  (w_t_vld),
    .o_ca   (w_t_ca),
    .o_sum  (w_sum)
  );

  assign w_y = round_shift(acc_t'(signed'(w_sum)));

  // Output register: round, saturate and emit one pulse per computed sample.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_data_vld <= 1'b0;
      o_data_ca  <= 1'b0;
      o_data     <= '0;
    end else begin
      o_data_vld <= w_t_vld;
      o_data_ca  <= w_t_ca & w_t_vld;
      if (w_t_vld) begin
        o_data <= saturate(w_y);
      end else begin
        o_data <= o_data;
      end
    end
  end

`ifdef DEC_SAT_FLAG_EN
  // Clip indicator aligned with the output pulse.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      o_sat_flag <= 1'b0;
    end else begin
      o_sat_flag <= w_t_vld & is_clipped(w_y);
    end
  end
`endif

endmodule

// File: tb/tb_down491m_to_245m.sv
// Self-checking bench for down491m_to_245m: directed scenarios plus random
// streaming, compared against a behavioural decimating-FIR model.
module tb_down491m_to_245m;

  localparam int L   = 16;
  localparam int LAT = 5;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_data_vld;
  logic        i_data_ca;
  logic [15:0] i_data;
  logic        i_load_parameter;
  logic [15:0] i_parameter_data;
  logic        o_data_vld;
  logic        o_data_ca;
  logic [15:0] o_data;
`ifdef DEC_SAT_FLAG_EN
  logic        o_sat_flag;
`endif

  down491m_to_245m dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_data_vld       (i_data_vld),
    .i_data_ca        (i_data_ca),
    .i_data           (i_data),
    .i_load_parameter (i_load_parameter),
    .i_parameter_data (i_parameter_data),
`ifdef DEC_SAT_FLAG_EN
    .o_sat_flag       (o_sat_flag),
`endif
    .o_data_vld       (o_data_vld),
    .o_data_ca        (o_data_ca),
    .o_data           (o_data)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int due;
    int y;
    bit ca;
    bit clip;
  } exp_t;

  exp_t q[$];
  int   hist[L];
  int   h[L];
  int   ptr;
  bit   phase;
  int   cyc;
  int   n_checks;
  int   n_errors;

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d want=%0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Behavioural model: filter over the last L accepted samples, keep phase-0 results.
  task automatic model(input int rst, input int vld, input int ca, input int d,
                       input int ld, input int pd);
    bit     cur;
    longint sum;
    longint y;
    exp_t   e;
    if (rst == 0) begin
      hist  = '{default: 0};
      h     = '{default: 0};
      ptr   = 0;
      phase = 1'b0;
      q.delete();
    end else begin
      if (ld != 0) begin
        h[ptr] = pd;
        ptr    = (ptr + 1) % L;
      end else begin
        ptr = 0;
      end
      if (vld != 0) begin
        for (int i = L - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = d;
        cur   = (ca != 0) ? 1'b0 : phase;
        phase = !cur;
        if (!cur) begin
          sum = 0;
          for (int i = 0; i < L; i++) sum += longint'(hist[i]) * longint'(h[i]);
          y = (sum + 16384) >>> 15;
          e.clip = (y > 32767) || (y < -32768);
          if (y > 32767) y = 32767;
          else if (y < -32768) y = -32768;
          e.due = cyc + LAT;
          e.y   = int'(y);
          e.ca  = (ca != 0);
          q.push_back(e);
        end
      end
    end
  endtask

  // One clock: drive inputs, update the model at the edge, check at the falling edge.
  task automatic tick(input int rst, input int vld, input int ca, input int d,
                      input int ld, input int pd);
    i_rst            = (rst != 0);
    i_data_vld       = (vld != 0);
    i_data_ca        = (ca != 0);
    i_data           = d[15:0];
    i_load_parameter = (ld != 0);
    i_parameter_data = pd[15:0];
    @(posedge i_clk);
    cyc++;
    model(rst, vld, ca, d, ld, pd);
    @(negedge i_clk);
    if (rst == 0) begin
      check("rst_vld", o_data_vld, 0);
      check("rst_ca", o_data_ca, 0);
      check("rst_data", longint'($signed(o_data)), 0);
    end else if (q.size() > 0 && q[0].due == cyc) begin
      check("out_vld", o_data_vld, 1);
      check("out_data", longint'($signed(o_data)), q[0].y);
      check("out_ca", o_data_ca, q[0].ca);
`ifdef DEC_SAT_FLAG_EN
      check("sat_flag", o_sat_flag, q[0].clip);
`endif
      void'(q.pop_front());
    end else begin
      check("idle_vld", o_data_vld, 0);
`ifdef DEC_SAT_FLAG_EN
      check("idle_sat", o_sat_flag, 0);
`endif
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(1, 0, 0, 0, 0, 0);
  endtask

  task automatic load_impulse();
    for (int i = 0; i < L; i++) tick(1, 0, 0, 0, 1, (i == 0) ? 32767 : 0);
    tick(1, 0, 0, 0, 0, 0);
  endtask

  task automatic load_const(input int v);
    for (int i = 0; i < L; i++) tick(1, 0, 0, 0, 1, v);
    tick(1, 0, 0, 0, 0, 0);
  endtask

  task automatic impulse_stream();
    for (int v = 1; v <= 20; v++) tick(1, 1, (v == 1) ? 1 : 0, v, 0, 0);
    idle(8);
  endtask

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  initial begin
    n_checks = 0;
    n_errors = 0;
    cyc      = 0;

    // Reset held with random inputs.
    for (int i = 0; i < 4; i++)
      tick(0, int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), rnd16(),
           int'($urandom_range(0, 1)), rnd16());
    idle(3);

    // Impulse response: outputs 1,3,5,... with ca only on the first.
    load_impulse();
    impulse_stream();

    // Saturation at both rails.
    load_const(32767);
    for (int i = 0; i < 20; i++) tick(1, 1, (i == 0) ? 1 : 0, 32767, 0, 0);
    for (int i = 0; i < 20; i++) tick(1, 1, 0, -32768, 0, 0);
    idle(8);

    // Valid gaps: delay line frozen, outputs 10 and 30.
    load_impulse();
    tick(1, 1, 1, 10, 0, 0);
    tick(1, 0, 0, rnd16(), 0, 0);
    tick(1, 1, 0, 20, 0, 0);
    tick(1, 0, 0, rnd16(), 0, 0);
    tick(1, 1, 0, 30, 0, 0);
    tick(1, 0, 0, rnd16(), 0, 0);
    tick(1, 1, 0, 40, 0, 0);
    tick(1, 0, 0, rnd16(), 0, 0);
    idle(8);

    // ca realignment on what would be a phase-1 sample.
    for (int v = 1; v <= 12; v++) tick(1, 1, (v == 1 || v == 4) ? 1 : 0, v, 0, 0);
    idle(8);

    // Random coefficients and streaming, with occasional mid-stream loads.
    for (int i = 0; i < L; i++) tick(1, 0, 0, 0, 1, rnd16());
    tick(1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 400; i++)
      tick(1, ($urandom_range(0, 9) < 7) ? 1 : 0, ($urandom_range(0, 9) == 0) ? 1 : 0,
           rnd16(), ($urandom_range(0, 19) == 0) ? 1 : 0, rnd16());
    idle(8);

    // Reset mid-operation: pointer at 7 and outputs in flight.
    for (int i = 0; i < 7; i++) tick(1, 1, (i == 0) ? 1 : 0, 100 + i, 1, rnd16());
    tick(0, 0, 0, 0, 0, 0);
    tick(0, 1, 0, 5, 1, 7);
    idle(10);
    load_impulse();
    impulse_stream();

    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
